// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 5-8 data bits LSB-first, optional parity, 1-2 stop bits, 16 clken ticks per bit.
// Optional CTS flow control is enabled by defining UART_TX_CTS_FLOW_EN.
module uart_transmitter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [1:0]            cfg_data_bit_num,
    input  logic                  cfg_stop_bit_num,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_type,
    input  logic                  host_read_stt_tx_done,
    input  logic                  cts_n,
    output logic                  tx,
    output logic                  stt_tx_busy,
    output logic                  stt_tx_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state, state_next;
    logic [3:0] sample, sample_next;
    logic [2:0] bitpos, bitpos_next;
    logic       stop_cnt, stop_cnt_next;
    logic [7:0] shift, shift_next;
    logic       parity, parity_next;
    logic [1:0] nbits, nbits_next;
    logic       stop2, stop2_next;
    logic       par_en, par_en_next;
    logic       tx_next, busy_next, done_next;

    logic [DATA_WIDTH+7:0] padded;
    logic [7:0] char_in;
    logic [7:0] char_mask;
    logic       accept;
    logic       bit_end;
    logic       unused_inputs;

    // Zero-padding lets any DATA_WIDTH feed the 8-bit character path.
    assign padded    = {8'h00, tx_data};
    assign char_in   = padded[7:0];
    assign char_mask = 8'hFF >> (2'd3 - cfg_data_bit_num);
    assign bit_end   = clken && (sample == 4'd15);

`ifdef UART_TX_CTS_FLOW_EN
    assign accept        = (state == IDLE) && tx_start && !cts_n;
    assign unused_inputs = ^padded;
`else
    assign accept        = (state == IDLE) && tx_start;
    assign unused_inputs = ^{padded, cts_n};
`endif

    always_comb begin
        state_next    = state;
        sample_next   = sample;
        bitpos_next   = bitpos;
        stop_cnt_next = stop_cnt;
        shift_next    = shift;
        parity_next   = parity;
        nbits_next    = nbits;
        stop2_next    = stop2;
        par_en_next   = par_en;
        done_next     = stt_tx_done;

        if (state != IDLE && clken)
            sample_next = sample + 4'd1;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next  = START;
                    sample_next = 4'd0;
                    shift_next  = char_in;
                    nbits_next  = cfg_data_bit_num;
                    stop2_next  = cfg_stop_bit_num;
                    par_en_next = cfg_parity_en;
                    parity_next = ^(char_in & char_mask) ^ cfg_parity_type;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next  = DATA;
                    bitpos_next = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bitpos_next = bitpos + 3'd1;
                    if (bitpos == 3'd4 + {1'b0, nbits}) begin
                        state_next    = par_en ? PARITY : STOP;
                        stop_cnt_next = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    stop_cnt_next = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt == stop2) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A host read on the same cycle as completion leaves the flag clear.
        if (host_read_stt_tx_done)
            done_next = 1'b0;

        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[bitpos_next];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sample      <= 4'd0;
            bitpos      <= 3'd0;
            stop_cnt    <= 1'b0;
            shift       <= 8'h00;
            parity      <= 1'b0;
            nbits       <= 2'd0;
            stop2       <= 1'b0;
            par_en      <= 1'b0;
            tx          <= 1'b1;
            stt_tx_busy <= 1'b0;
            stt_tx_done <= 1'b0;
        end else begin
            state       <= state_next;
            sample      <= sample_next;
            bitpos      <= bitpos_next;
            stop_cnt    <= stop_cnt_next;
            shift       <= shift_next;
            parity      <= parity_next;
            nbits       <= nbits_next;
            stop2       <= stop2_next;
            par_en      <= par_en_next;
            tx          <= tx_next;
            stt_tx_busy <= busy_next;
            stt_tx_done <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter; expected frames are hand-written bit strings
// (start, data LSB-first, parity, stop). Define UART_TX_CTS_FLOW_EN to also exercise CTS gating.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clken = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] cfg_data_bit_num;
    logic       cfg_stop_bit_num;
    logic       cfg_parity_en;
    logic       cfg_parity_type;
    logic       host_read_stt_tx_done;
    logic       cts_n;
    logic       tx;
    logic       stt_tx_busy;
    logic       stt_tx_done;

    int clken_div = 1;
    int div_cnt   = 0;
    int total     = 0;
    int bad       = 0;

    uart_transmitter #(.DATA_WIDTH(8)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .clken                 (clken),
        .tx_start              (tx_start),
        .tx_data               (tx_data),
        .cfg_data_bit_num      (cfg_data_bit_num),
        .cfg_stop_bit_num      (cfg_stop_bit_num),
        .cfg_parity_en         (cfg_parity_en),
        .cfg_parity_type       (cfg_parity_type),
        .host_read_stt_tx_done (host_read_stt_tx_done),
        .cts_n                 (cts_n),
        .tx                    (tx),
        .stt_tx_busy           (stt_tx_busy),
        .stt_tx_done           (stt_tx_done)
    );

    always #5 clk = ~clk;

    // clken changes shortly after the rising edge so it is stable when sampled at the falling edge.
    always @(posedge clk) begin
        #2;
        if (div_cnt >= clken_div - 1) div_cnt = 0;
        else div_cnt = div_cnt + 1;
        clken = (div_cnt == 0);
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Send one character and compare tx against the expected bit string for every cycle of the frame.
    task automatic apply_stimulus(input string tag, input logic [7:0] data, input logic [1:0] nb,
                                  input logic sb, input logic pe, input logic pt, input string bits,
                                  input bit inject, input bit clear_at_end);
        int pulses;
        int cycles;
        int limit;
        int total_pulses;
        int idx;
        bit injected;
        logic exp_bit;

        @(negedge clk);
        host_read_stt_tx_done = 1'b1;
        @(negedge clk);
        host_read_stt_tx_done = 1'b0;
        check_output({tag, "_done_clear"}, {31'd0, stt_tx_done}, 32'd0);

        tx_data          = data;
        cfg_data_bit_num = nb;
        cfg_stop_bit_num = sb;
        cfg_parity_en    = pe;
        cfg_parity_type  = pt;
        tx_start         = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;

        total_pulses = 16 * bits.len();
        limit        = total_pulses * clken_div + 50;
        pulses       = 0;
        cycles       = 0;
        injected     = 1'b0;
        while (pulses < total_pulses && cycles < limit) begin
            idx     = pulses / 16;
            exp_bit = (bits[idx] == 8'h31);
            check_output({tag, "_tx"}, {31'd0, tx}, {31'd0, exp_bit});
            check_output({tag, "_busy"}, {31'd0, stt_tx_busy}, 32'd1);
            tx_start              = 1'b0;
            host_read_stt_tx_done = 1'b0;
            if (inject && !injected && pulses == 40) begin
                tx_start         = 1'b1;
                tx_data          = 8'hAA;
                cfg_data_bit_num = 2'b00;
                cfg_parity_en    = 1'b1;
                injected         = 1'b1;
            end
            if (clear_at_end && clken && (pulses + 1 == total_pulses))
                host_read_stt_tx_done = 1'b1;
            if (clken) pulses++;
            cycles++;
            @(negedge clk);
        end
        tx_start              = 1'b0;
        host_read_stt_tx_done = 1'b0;

        check_output({tag, "_in_budget"}, {31'd0, cycles < limit}, 32'd1);
        if (clken_div == 1)
            check_output({tag, "_busy_cycles"}, cycles, total_pulses);
        check_output({tag, "_end_tx"}, {31'd0, tx}, 32'd1);
        check_output({tag, "_end_busy"}, {31'd0, stt_tx_busy}, 32'd0);
        check_output({tag, "_end_done"}, {31'd0, stt_tx_done}, {31'd0, !clear_at_end});

        repeat (40) @(negedge clk);
        check_output({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
        check_output({tag, "_idle_busy"}, {31'd0, stt_tx_busy}, 32'd0);
    endtask

    initial begin
        int waited;

        reset                 = 1'b1;
        tx_start              = 1'b0;
        tx_data               = 8'h00;
        cfg_data_bit_num      = 2'b11;
        cfg_stop_bit_num      = 1'b0;
        cfg_parity_en         = 1'b0;
        cfg_parity_type       = 1'b0;
        host_read_stt_tx_done = 1'b0;
`ifdef UART_TX_CTS_FLOW_EN
        cts_n = 1'b0;
`else
        cts_n = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check_output("reset_tx", {31'd0, tx}, 32'd1);
        check_output("reset_busy", {31'd0, stt_tx_busy}, 32'd0);
        check_output("reset_done", {31'd0, stt_tx_done}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        apply_stimulus("8N1_55", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, "0101010101", 1'b0, 1'b0);
        apply_stimulus("8E1_03", 8'h03, 2'b11, 1'b0, 1'b1, 1'b0, "01100000001", 1'b0, 1'b0);
        apply_stimulus("8O2_03", 8'h03, 2'b11, 1'b1, 1'b1, 1'b1, "011000000111", 1'b0, 1'b0);
        apply_stimulus("mid_0F", 8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, "0111100001", 1'b1, 1'b1);
        apply_stimulus("5N1_E0", 8'hE0, 2'b00, 1'b0, 1'b0, 1'b0, "0000001", 1'b0, 1'b0);

        // Abort a frame in its data bits; done is still set from the previous frame.
        clken_div = 4;
        @(negedge clk);
        tx_data          = 8'h41;
        cfg_data_bit_num = 2'b11;
        cfg_stop_bit_num = 1'b0;
        cfg_parity_en    = 1'b0;
        tx_start         = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * 16 * 3) @(negedge clk);
        check_output("abort_busy_before", {31'd0, stt_tx_busy}, 32'd1);
        check_output("abort_done_before", {31'd0, stt_tx_done}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_output("abort_tx", {31'd0, tx}, 32'd1);
        check_output("abort_busy", {31'd0, stt_tx_busy}, 32'd0);
        check_output("abort_done", {31'd0, stt_tx_done}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_output("abort_idle_tx", {31'd0, tx}, 32'd1);

        apply_stimulus("8N1_41_div4", 8'h41, 2'b11, 1'b0, 1'b0, 1'b0, "0100000101", 1'b0, 1'b0);

`ifdef UART_TX_CTS_FLOW_EN
        clken_div = 1;
        @(negedge clk);
        cts_n    = 1'b1;
        tx_data  = 8'h55;
        tx_start = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_output("cts_hold_tx", {31'd0, tx}, 32'd1);
            check_output("cts_hold_busy", {31'd0, stt_tx_busy}, 32'd0);
        end
        cts_n = 1'b0;
        @(negedge clk);
        check_output("cts_start_tx", {31'd0, tx}, 32'd0);
        check_output("cts_start_busy", {31'd0, stt_tx_busy}, 32'd1);
        tx_start = 1'b0;
        cts_n    = 1'b1;
        waited   = 0;
        while (stt_tx_busy && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check_output("cts_frame_completes", {31'd0, stt_tx_busy}, 32'd0);
        check_output("cts_frame_length", waited, 32'd159);
        check_output("cts_frame_done", {31'd0, stt_tx_done}, 32'd1);
`else
        waited = 0;
        check_output("cts_ignored_idle", {31'd0, stt_tx_busy}, waited);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises one host-written character into an asynchronous UART frame on `tx`. Frame order is start bit, 5-8 data bits LSB-first, optional parity, then 1-2 stop bits.
Every bit is held for 16 pulses of the shared baud-rate `clken`, so the block pairs with the UART receiver on the same 16x oversample tick and frame configuration fields.
Sits beside the receiver in the dti_uart block and is driven by the register interface.

Parameters:
DATA_WIDTH, 8, width of `tx_data`; only bits [7:0] are ever transmitted, higher bits are ignored.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
clken  input  1  16x baud tick, one clk cycle wide
tx_start  input  1  host request to send `tx_data`; accepted only when `stt_tx_busy`=0
tx_data  input  DATA_WIDTH  character to send, sampled when `tx_start` is accepted
cfg_data_bit_num  input  2  data bits: 00=5, 01=6, 10=7, 11=8
cfg_stop_bit_num  input  1  0=1 stop bit, 1=2 stop bits
cfg_parity_en  input  1  1=insert parity bit
cfg_parity_type  input  1  0=even, 1=odd
host_read_stt_tx_done  input  1  clears `stt_tx_done`
cts_n  input  1  clear-to-send from far end, active low
tx  output  1  serial line, idle high
stt_tx_busy  output  1  high from acceptance until the last stop bit ends
stt_tx_done  output  1  sticky frame-complete status

Behaviour:
- States:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[bitpos].
  - PARITY: tx=parity.
  - STOP: tx=1.
- Reset values:
  - state=IDLE, tx=1, stt_tx_busy=0, stt_tx_done=0.
  - sample counter=0, bitpos=0, stop count=0, shift=0.
- Acceptance:
  - Occurs in IDLE when tx_start=1 (and, if enabled, CTS permits).
  - On that edge the block latches tx_data[7:0], all cfg_* fields and the parity bit.
  - Parity bit = XOR of the enabled data bits, XOR cfg_parity_type.
  - Next cycle: state=START, tx=0, stt_tx_busy=1, sample=0.
  - Latency from tx_start to tx falling is 1 clk.
- Bit timing:
  - `sample` (4 bits) increments only on clk cycles with clken=1.
  - When clken=1 and sample=15, sample wraps to 0 and the bit ends.
  - Each bit therefore lasts exactly 16 clken pulses.
  - Without clken, all state holds.
- Transitions, taken at each bit end:
  - START -> DATA with bitpos=0.
  - DATA: bitpos+1; when bitpos = width-1, go to PARITY if cfg_parity_en, else STOP.
  - PARITY -> STOP.
  - STOP: when the stop count reaches the latched number of stop bits, go to IDLE; stt_tx_busy=0 the next cycle.
- Frame length:
  - 16*(1+N+P+S) clken pulses.
  - Data bits above the configured width are never sent.
- stt_tx_done:
  - Set on the cycle the final stop bit ends.
  - Cleared by host_read_stt_tx_done, which wins if both occur in the same cycle.
  - Holds otherwise.
- Simultaneous and mid-frame events:
  - tx_start while busy is ignored and does not corrupt the frame in flight.
  - cfg_* and tx_data changes mid-frame have no effect on the current frame.
  - tx_start on the cycle the block returns to IDLE: accepted in the first IDLE cycle only.
- Reset mid-frame: the frame is aborted, tx=1 on the next edge, and all status bits return to their reset values.

Optional Feature:
- Macro: UART_TX_CTS_FLOW_EN.
- Defined:
  - In IDLE, tx_start is accepted only while cts_n=0.
  - A pending tx_start held high is accepted on the first cycle cts_n=0.
  - cts_n rising mid-frame does not stop the current frame; the frame always completes.
- Undefined: cts_n is ignored and acceptance depends only on tx_start and stt_tx_busy.

Test Plan:
- 8N1, tx_data=0x55, clken every clk, tx_start pulse -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 16 clk; busy for 160 cycles; stt_tx_done=1 after; tx=1.
- 8E1, tx_data=0x03 -> parity bit 0; same data with 8O2 -> parity bit 1, two stop bits, 192 clken pulses total.
- 5N1, tx_data=0xE0 -> five data bits all 0, bits 7:5 not sent, frame 112 clken pulses.
- Second tx_start mid-frame with data 0xAA during a 0x0F transfer -> 0x0F sent intact, 0xAA never sent; host_read_stt_tx_done coincident with the done-set cycle -> stt_tx_done stays 0.
- clken every 4th clk, reset asserted in DATA state -> tx=1, stt_tx_busy=0 next cycle; a fresh 0x41 frame afterwards is correct.
- With UART_TX_CTS_FLOW_EN, cts_n=1 and tx_start held high -> tx stays 1; cts_n falls -> tx=0 one clk later.
